// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit-level driver: commands, phase states, divider width,
// and the per-phase SCL/SDA drive table.
package i2c_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    PH_A,
    PH_B,
    PH_C,
    PH_D
  } phase_e;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low.
  function automatic logic [1:0] line_drive(cmd_e cmd, logic din, phase_e ph);
    logic scl;
    logic sda;
    scl = 1'b0;
    sda = 1'b0;
    case (cmd)
      CMD_START: begin
        scl = (ph == PH_D);
        sda = (ph == PH_C) || (ph == PH_D);
      end
      CMD_STOP: begin
        scl = (ph == PH_A);
        sda = (ph != PH_D);
      end
      CMD_WRITE: begin
        scl = (ph == PH_A) || (ph == PH_D);
        sda = ~din;
      end
      default: begin
        scl = (ph == PH_A) || (ph == PH_D);
        sda = 1'b0;
      end
    endcase
    return {scl, sda};
  endfunction

endpackage

// File: rtl/i2c_bit_tx_if.sv
// Command handshake between the byte-level controller (master) and the bit driver (slave).
interface i2c_bit_tx_if;

  logic            cmd_valid;
  logic            cmd_ready;
  i2c_pkg::cmd_e   cmd;
  logic            cmd_din;
  logic            done;
  logic            dout;
  logic            arb_lost;
  logic            busy;

  modport master (
    output cmd_valid, cmd, cmd_din,
    input  cmd_ready, done, dout, arb_lost, busy
  );

  modport slave (
    input  cmd_valid, cmd, cmd_din,
    output cmd_ready, done, dout, arb_lost, busy
  );

endinterface

// File: rtl/i2c_phase_timer.sv
// Phase down-counter: load sets CLK_DIV-1, expire on the last counted cycle of a phase.
// hold freezes the count (SCL stretching) and masks expire.
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter logic [DIV_W-1:0] CLK_DIV = 16'd250
) (
  input  logic clk,
  input  logic asyn_rst_n,
  input  logic load,
  input  logic hold,
  output logic expire
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CLK_DIV - DIV_W'(1);
    end else if (!hold && cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign expire = (cnt == '0) && !hold;

endmodule

// File: rtl/i2c_bit_tx.sv
// Bit-level I2C line driver: one START/STOP/WRITE/READ per accepted command, four phases of
// CLK_DIV cycles (4*CLK_DIV plus SCL stretch); cmd_ready only while idle, registered outputs.
module i2c_bit_tx
  import i2c_pkg::*;
#(
  parameter logic [DIV_W-1:0] CLK_DIV = 16'd250
) (
  input  logic         clk,
  input  logic         asyn_rst_n,
  i2c_bit_tx_if.slave  cmd_if,
  input  logic         scl_in,
  input  logic         sda_in,
  output logic         scl_oe,
  output logic         sda_oe
);

  phase_e state;
  cmd_e   cmd_q;
  logic   din_q;
  logic   expire;
  logic   hold;
  logic   load;
  logic   arb_check;
  logic   arb_hit;
  logic   done_r;
  logic   dout_r;
  logic   arb_r;
  logic   busy_r;
  logic   ready_r;

  function automatic phase_e next_phase(phase_e ph);
    case (ph)
      PH_A:    return PH_B;
      PH_B:    return PH_C;
      PH_C:    return PH_D;
      default: return IDLE;
    endcase
  endfunction

  // A slave holding SCL low after we release it stretches the current phase.
  assign hold = ~scl_oe & ~scl_in;

  assign arb_check = ((cmd_q == CMD_WRITE) && din_q && (state == PH_B || state == PH_C)) ||
                     ((cmd_q == CMD_STOP) && (state == PH_D));
  assign arb_hit   = arb_check & ~sda_in;

  assign load = (state == IDLE) ? cmd_if.cmd_valid
                                : (expire && !arb_hit && state != PH_D);

  i2c_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .asyn_rst_n (asyn_rst_n),
    .load       (load),
    .hold       (hold),
    .expire     (expire)
  );

  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      state   <= IDLE;
      cmd_q   <= CMD_START;
      din_q   <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      done_r  <= 1'b0;
      arb_r   <= 1'b0;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      arb_r  <= 1'b0;
      if (state == IDLE) begin
        if (cmd_if.cmd_valid) begin
          state            <= PH_A;
          cmd_q            <= cmd_if.cmd;
          din_q            <= cmd_if.cmd_din;
          {scl_oe, sda_oe} <= line_drive(cmd_if.cmd, cmd_if.cmd_din, PH_A);
          busy_r           <= 1'b1;
          ready_r          <= 1'b0;
        end
      end else if (expire) begin
        if (state == PH_B && cmd_q == CMD_READ) begin
          dout_r <= sda_in;
        end
        if (arb_hit) begin
          state            <= IDLE;
          {scl_oe, sda_oe} <= 2'b00;
          arb_r            <= 1'b1;
          busy_r           <= 1'b0;
          ready_r          <= 1'b1;
        end else if (state == PH_D) begin
          // Lines keep the PH_D drive while idle.
          state   <= IDLE;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end else begin
          state            <= next_phase(state);
          {scl_oe, sda_oe} <= line_drive(cmd_q, din_q, next_phase(state));
        end
      end
    end
  end

  assign cmd_if.cmd_ready = ready_r;
  assign cmd_if.done      = done_r;
  assign cmd_if.dout      = dout_r;
  assign cmd_if.arb_lost  = arb_r;
  assign cmd_if.busy      = busy_r;

  div_legal: assert property (@(posedge clk) CLK_DIV >= DIV_W'(2));

endmodule

// File: tb/tb_i2c_bit_tx.sv
// Directed bench for i2c_bit_tx at CLK_DIV=4: per-command phase table plus arbitration,
// stretching, back-to-back and mid-command reset sequences.
module tb_i2c_bit_tx;
  import i2c_pkg::*;

  logic clk;
  logic asyn_rst_n;
  logic scl_in;
  logic sda_in;
  logic scl_oe;
  logic sda_oe;
  logic pull;
  logic stretch;

  i2c_bit_tx_if ifc ();

  i2c_bit_tx #(
    .CLK_DIV (16'd4)
  ) dut (
    .clk        (clk),
    .asyn_rst_n (asyn_rst_n),
    .cmd_if     (ifc),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
  );

  // Open-drain bus: the bench can pull either line low on top of the DUT.
  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & ~pull;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic scl_tr   [0:63];
  logic sda_tr   [0:63];
  logic ready_tr [0:63];
  logic busy_tr  [0:63];
  logic arb_tr   [0:63];
  int   done_at;
  int   arb_at;
  int   ndone;

  typedef struct {
    cmd_e       c;
    logic       d;
    logic       pull;
    logic [7:0] ln;    // {scl_oe,sda_oe} for phases A,B,C,D, MSB first
    logic       dout;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one command at the current negedge, then trace maxk cycles; k=1 is the first
  // cycle after the accept edge. pull/stretch are active for k in [from, to).
  task automatic run_cmd(input cmd_e c, input logic d, input int pf, input int pt,
                         input int sf, input int st, input int maxk);
    ifc.cmd       = c;
    ifc.cmd_din   = d;
    ifc.cmd_valid = 1'b1;
    pull    = (pf <= 0) && (0 < pt);
    stretch = (sf <= 0) && (0 < st);
    done_at = 0;
    arb_at  = 0;
    ndone   = 0;
    for (int k = 1; k <= maxk; k++) begin
      @(negedge clk);
      scl_tr[k]   = scl_oe;
      sda_tr[k]   = sda_oe;
      ready_tr[k] = ifc.cmd_ready;
      busy_tr[k]  = ifc.busy;
      arb_tr[k]   = ifc.arb_lost;
      if (ifc.done) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (ifc.arb_lost && arb_at == 0) arb_at = k;
      if (k == 1) ifc.cmd_valid = 1'b0;
      pull    = (pf <= k) && (k < pt);
      stretch = (sf <= k) && (k < st);
    end
    pull    = 1'b0;
    stretch = 1'b0;
  endtask

  initial begin
    cmd_e        q [3];
    int          dk [3];
    int          nd;
    int          pend;
    logic        pres;
    logic [1:0]  e2;
    int          rst_done;

    vt[0] = '{c: CMD_START, d: 1'b0, pull: 1'b0, ln: 8'b00_00_01_11, dout: 1'b0};
    vt[1] = '{c: CMD_READ,  d: 1'b0, pull: 1'b0, ln: 8'b10_00_00_10, dout: 1'b1};
    vt[2] = '{c: CMD_WRITE, d: 1'b1, pull: 1'b0, ln: 8'b10_00_00_10, dout: 1'b1};
    vt[3] = '{c: CMD_READ,  d: 1'b0, pull: 1'b1, ln: 8'b10_00_00_10, dout: 1'b0};
    vt[4] = '{c: CMD_WRITE, d: 1'b0, pull: 1'b0, ln: 8'b11_01_01_11, dout: 1'b0};
    vt[5] = '{c: CMD_STOP,  d: 1'b0, pull: 1'b0, ln: 8'b11_01_01_00, dout: 1'b0};
    vt[6] = '{c: CMD_READ,  d: 1'b0, pull: 1'b0, ln: 8'b10_00_00_10, dout: 1'b1};

    ifc.cmd_valid = 1'b0;
    ifc.cmd       = CMD_START;
    ifc.cmd_din   = 1'b0;
    pull          = 1'b0;
    stretch       = 1'b0;
    asyn_rst_n    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst scl_oe",    32'(scl_oe), 0);
    chk("rst sda_oe",    32'(sda_oe), 0);
    chk("rst done",      32'(ifc.done), 0);
    chk("rst arb_lost",  32'(ifc.arb_lost), 0);
    chk("rst dout",      32'(ifc.dout), 0);
    chk("rst busy",      32'(ifc.busy), 0);
    chk("rst cmd_ready", 32'(ifc.cmd_ready), 1);
    asyn_rst_n = 1'b1;
    @(negedge clk);

    // Per-command phase table
    for (int i = 0; i < 7; i++) begin
      run_cmd(vt[i].c, vt[i].d, 0, vt[i].pull ? 17 : 0, 0, 0, 18);
      for (int p = 0; p < 4; p++) begin
        e2 = vt[i].ln[7-2*p -: 2];
        chk($sformatf("v%0d lines ph%0d", i, p), 32'({scl_tr[4*p+2], sda_tr[4*p+2]}), 32'(e2));
      end
      chk($sformatf("v%0d busy", i), 32'(busy_tr[1]), 1);
      chk($sformatf("v%0d done_at", i), 32'(done_at), 17);
      chk($sformatf("v%0d ready at done", i), 32'(ready_tr[17]), 1);
      chk($sformatf("v%0d arb", i), 32'(arb_at), 0);
      chk($sformatf("v%0d dout", i), 32'(ifc.dout), 32'(vt[i].dout));
    end

    // WRITE 1 losing arbitration at the end of PH_B
    run_cmd(CMD_WRITE, 1'b1, 5, 9, 0, 0, 20);
    chk("arbw sda released", 32'(sda_tr[6]), 0);
    chk("arbw arb_at",       32'(arb_at), 9);
    chk("arbw lines",        32'({scl_tr[9], sda_tr[9]}), 0);
    chk("arbw ready",        32'(ready_tr[9]), 1);
    chk("arbw pulse width",  32'(arb_tr[10]), 0);
    chk("arbw no done",      32'(ndone), 0);

    // STOP losing arbitration in PH_D
    run_cmd(CMD_STOP, 1'b0, 13, 17, 0, 0, 20);
    chk("arbs arb_at",  32'(arb_at), 17);
    chk("arbs no done", 32'(ndone), 0);

    // Clock stretch of 20 cycles from the start of PH_B
    run_cmd(CMD_WRITE, 1'b0, 0, 0, 5, 25, 45);
    chk("str scl released", 32'(scl_tr[20]), 0);
    chk("str done_at",      32'(done_at), 37);
    chk("str ndone",        32'(ndone), 1);
    chk("str arb",          32'(arb_at), 0);

    // Back-to-back START, WRITE 1, STOP with cmd_valid held high
    q[0] = CMD_START; q[1] = CMD_WRITE; q[2] = CMD_STOP;
    dk[0] = 0; dk[1] = 0; dk[2] = 0;
    nd = 0; pend = 1; pres = 1'b1;
    ifc.cmd = q[0]; ifc.cmd_din = 1'b0; ifc.cmd_valid = 1'b1;
    for (int k = 1; k <= 60 && nd < 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("b2b ready while busy", 32'(ifc.cmd_ready), 0);
      if (k == 23) chk("b2b write lines", 32'({scl_oe, sda_oe}), 0);
      if (ifc.done) begin
        dk[nd] = k;
        nd++;
        pres = 1'b1;
        if (nd == 3) begin
          chk("b2b stop lines", 32'({scl_oe, sda_oe}), 0);
          ifc.cmd_valid = 1'b0;
        end
      end else if (pres && pend < 3) begin
        ifc.cmd     = q[pend];
        ifc.cmd_din = (q[pend] == CMD_WRITE);
        pend++;
        pres = 1'b0;
      end
    end
    chk("b2b done0", 32'(dk[0]), 17);
    chk("b2b done1", 32'(dk[1]), 34);
    chk("b2b done2", 32'(dk[2]), 51);
    @(negedge clk);
    chk("b2b idle busy", 32'(ifc.busy), 0);

    // Reset in the middle of PH_C of a WRITE 0
    ifc.cmd = CMD_WRITE; ifc.cmd_din = 1'b0; ifc.cmd_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) ifc.cmd_valid = 1'b0;
    end
    chk("rstc sda before", 32'(sda_oe), 1);
    asyn_rst_n = 1'b0;
    #1;
    chk("rstc sda_oe", 32'(sda_oe), 0);
    chk("rstc scl_oe", 32'(scl_oe), 0);
    chk("rstc busy",   32'(ifc.busy), 0);
    @(negedge clk);
    asyn_rst_n = 1'b1;
    rst_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.done) rst_done++;
    end
    chk("rstc no done", 32'(rst_done), 0);
    chk("rstc ready",   32'(ifc.cmd_ready), 1);
    chk("rstc dout",    32'(ifc.dout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
